// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type/width and baud-mode codes with their
// clocks-per-bit table (50 MHz system clock). Used by the receiver,
// transmitter and the receive FIFO.
package uart_pkg;

  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_mode_t;

  // Clocks per bit at 50 MHz, indexed by baud_mode_t.
  localparam int unsigned CLKS_PER_BIT [5] = '{5208, 2604, 1302, 868, 434};

  function automatic int unsigned clks_per_bit(baud_mode_t mode);
    int unsigned cpb;
    case (mode)
      BAUD_9600:   cpb = CLKS_PER_BIT[0];
      BAUD_19200:  cpb = CLKS_PER_BIT[1];
      BAUD_38400:  cpb = CLKS_PER_BIT[2];
      BAUD_57600:  cpb = CLKS_PER_BIT[3];
      BAUD_115200: cpb = CLKS_PER_BIT[4];
      default:     cpb = CLKS_PER_BIT[0];
    endcase
    return cpb;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte streams around the receive FIFO.
//   in_data/in_valid   : strobe from the UART receiver (no backpressure)
//   out_data/out_valid/out_ready : valid/ready stream to the consumer
// slave  = FIFO side, master = receiver/consumer side.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  uart_byte_t in_data;
  logic       in_valid;
  uart_byte_t out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave  (input  in_data, in_valid, out_ready,
                  output out_data, out_valid);
  modport master (output in_data, in_valid, out_ready,
                  input  out_data, out_valid);
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage, one write port and one registered read port.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr   : read request; rdata loads mem[raddr] when re, else 0
//   rdata      : registered read data
// A write to the address being read in the same cycle returns the new
// byte, so a byte pushed into an (about to be) empty FIFO is at the head
// one clock later.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rdata <= '0;
    else if (!re)                 rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else                          rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Captures one byte per
// in_valid strobe, presents bytes first-word-fall-through on a registered
// valid/ready stream, and reports level/full/empty and a sticky overflow.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : in_data/in_valid, out_data/out_valid/out_ready
//   level         : occupancy 0..DEPTH
//   full, empty   : level==DEPTH, level==0
//   overflow      : sticky, a byte was dropped while full; ovf_clr clears
//   idle_timeout  : data waiting and no push/pop for TIMEOUT_CYCLES clocks
// Build option: define RX_FIFO_TIMEOUT_EN to include the idle counter;
// otherwise idle_timeout is tied to 0 (port list unchanged).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 156240,
  localparam int AW            = $clog2(DEPTH),
  localparam int PW            = AW + 1,
  localparam int LW            = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_fifo_if.slave        bus,
  output logic [LW-1:0]        level,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 idle_timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be >= 1");
  end

  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, occ_n;
  logic          push, pop, drop, nonempty_n;
  uart_byte_t    rd_data;

  assign pop  = bus.out_valid & bus.out_ready;
  // When full a push is still accepted if the head leaves this cycle.
  assign push = bus.in_valid & (~full | pop);
  assign drop = bus.in_valid & full & ~pop;

  assign wptr_n     = wptr + PW'(push);
  assign rptr_n     = rptr + PW'(pop);
  assign occ_n      = wptr_n - rptr_n;
  assign nonempty_n = (wptr_n != rptr_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      level <= LW'(occ_n);
      // Extra pointer bit separates full (wrapped) from empty.
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      empty <= ~nonempty_n;
      // A drop outranks a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head register: valid flag here, byte in the memory's read register,
  // both loaded from the post-update read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.out_valid <= 1'b0;
    else        bus.out_valid <= nonempty_n;
  end

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.in_data),
    .re    (nonempty_n),
    .raddr (rptr_n[AW-1:0]),
    .rdata (rd_data)
  );

  assign bus.out_data = rd_data;

`ifdef RX_FIFO_TIMEOUT_EN
  logic [31:0] idle_cnt, idle_cnt_n;

  always_comb begin
    idle_cnt_n = idle_cnt;
    if (push || pop || empty)  idle_cnt_n = '0;
    else if (idle_cnt != '1)   idle_cnt_n = idle_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt     <= '0;
      idle_timeout <= 1'b0;
    end else begin
      idle_cnt     <= idle_cnt_n;
      idle_timeout <= nonempty_n && !(push || pop) &&
                      (idle_cnt_n >= 32'(TIMEOUT_CYCLES));
    end
  end
`else
  assign idle_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] level;
  logic       full, empty, overflow, idle_timeout;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .idle_timeout (idle_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  uart_byte_t exp_q[$];

  // Scoreboard monitor: every accepted head byte must match the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got %02h, required no byte", bus.out_data);
      end else begin
        uart_byte_t e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_bad++;
          $display("FAIL pop_data: got %02h, required %02h", bus.out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flags(input string name, input int lvl);
    chk({name, "_level"}, 32'(level), 32'(lvl));
    chk({name, "_full"},  32'(full),  32'(lvl == DEPTH));
    chk({name, "_empty"}, 32'(empty), 32'(lvl == 0));
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(lvl != 0));
  endtask

  // Strobe one byte; expect it in the scoreboard only if it will be kept.
  task automatic strobe(input uart_byte_t b, input bit kept);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (kept) exp_q.push_back(b);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!empty && n < 40) begin
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    chk({name, "_drained"}, 32'(empty), 32'd1);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    flags("rst", 0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_tmo", 32'(idle_timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: three bytes held, then consecutive drain
    strobe(8'hA5, 1); strobe(8'h3C, 1); strobe(8'hFF, 1);
    flags("t1", 3);
    chk("t1_head", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    step(3);
    bus.out_ready = 1'b0;
    flags("t1_end", 0);
    chk("t1_data0", 32'(bus.out_data), 32'd0);
    bus.out_ready = 1'b1;           // ready while empty: no effect
    step(2);
    bus.out_ready = 1'b0;
    flags("t1_rdy_empty", 0);

    // 2: fill, 17th byte dropped
    for (int i = 0; i < 16; i++) strobe(uart_byte_t'(i), 1);
    chk("t2_ovf_pre", 32'(overflow), 32'd0);
    strobe(8'h99, 0);
    flags("t2_full", 16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    drain("t2");
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // 3: push accepted on a full FIFO when a pop frees a slot
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) strobe(uart_byte_t'(8'h20 + i), 1);
    bus.out_ready = 1'b1;
    strobe(8'h77, 1);
    bus.out_ready = 1'b0;
    flags("t3", 16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    drain("t3");

    // 4: drop wins over ovf_clr, then clear alone
    for (int i = 0; i < 16; i++) strobe(uart_byte_t'(8'hB0 + i), 1);
    strobe(8'h55, 0);
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    strobe(8'h66, 0);
    chk("t4_drop_wins", 32'(overflow), 32'd1);
    step();
    ovf_clr = 1'b0;
    chk("t4_clr", 32'(overflow), 32'd0);
    flags("t4", 16);
    drain("t4");

    // 5: async reset mid-drain
    for (int i = 0; i < 7; i++) strobe(uart_byte_t'(8'hD0 + i), 1);
    bus.out_ready = 1'b1;
    step(2);
    bus.out_ready = 1'b0;
    flags("t5_pre", 5);
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    flags("t5_rst", 0);
    chk("t5_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    strobe(8'hC3, 1);
    chk("t5_new_head", 32'(bus.out_data), 32'hC3);
    drain("t5");

    // 6: idle timeout
    strobe(8'h42, 1);
`ifdef RX_FIFO_TIMEOUT_EN
    step(99);
    chk("t6_tmo_99", 32'(idle_timeout), 32'd0);
    step();
    chk("t6_tmo_100", 32'(idle_timeout), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t6_tmo_pop", 32'(idle_timeout), 32'd0);
`else
    step(150);
    chk("t6_tmo_off", 32'(idle_timeout), 32'd0);
    drain("t6");
    chk("t6_tmo_off2", 32'(idle_timeout), 32'd0);
`endif
    step(2);
    chk("end_sb", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
